pc_fetch_control: RTL and testbench

//  Fetch-side consumer of the EX-stage branch/jump resolution (PCSrc/PCNew).
//  - Owns the program counter register and sequences PC updates.
//  - Accepts redirects, holds a redirect across fetch holds, and flushes the wrong-path instructions.
//  - Sits between the branch resolution logic and instruction memory / the IF/ID register.

---
 rtl/pc_fetch_control.sv | 131 +++++++++++++
 tb/tb_pc_fetch_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_control.sv
// Fetch PC sequencer: sequential increment, redirect capture across stalls, and wrong-path flush.
// Optional macro PC_ALIGN_CHECK_EN: word-align accepted targets and raise a sticky MisalignErr.
module pc_fetch_control #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned          PC_INC       = 4,
  parameter int unsigned          FLUSH_CYCLES = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                PCSrc,
  input  logic [PC_WIDTH-1:0] PCNew,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus4,
  output logic                Flush,
  output logic                RedirectPending,
  output logic                MisalignErr
);

  localparam logic [PC_WIDTH-1:0] PC_INC_W   = PC_WIDTH'(PC_INC);
  localparam logic [2:0]          FLUSH_INIT = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HELD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] held_q, held_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                pend_q, pend_d;
  logic [PC_WIDTH-1:0] pc_plus;
  logic [PC_WIDTH-1:0] tgt_raw;
  logic [PC_WIDTH-1:0] tgt_apply;
  logic                apply;

  assign pc_plus = pc_q + PC_INC_W;
  // A HELD release applies the captured target; a RUN redirect applies the live one.
  assign tgt_raw = (state_q == ST_HELD) ? held_q : PCNew;

`ifdef PC_ALIGN_CHECK_EN
  logic tgt_mis;
  logic err_q, err_d;

  assign tgt_apply = {tgt_raw[PC_WIDTH-1:2], 2'b00};
  assign tgt_mis   = |tgt_raw[1:0];
  assign err_d     = err_q | (apply & tgt_mis);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign MisalignErr = err_q;
`else
  assign tgt_apply   = tgt_raw;
  assign MisalignErr = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      held_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (PCSrc) begin
          if (Stall) begin
            held_d  = PCNew;
            state_d = ST_HELD;
          end else begin
            apply = 1'b1;
          end
        end else if (!Stall) begin
          pc_d = pc_plus;
        end
      end
      ST_HELD: begin
        if (!Stall) apply = 1'b1;
      end
      ST_FLUSH: begin
        if (!Stall) begin
          pc_d  = pc_plus;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (apply) begin
      pc_d    = tgt_apply;
      cnt_d   = FLUSH_INIT;
      state_d = (FLUSH_INIT == 3'd0) ? ST_RUN : ST_FLUSH;
    end
  end

  // Flush and RedirectPending are registered views of the state being entered.
  always_comb begin
    flush_d = (state_d == ST_FLUSH);
    pend_d  = (state_d == ST_HELD);
  end

  assign PC              = pc_q;
  assign PCPlus4         = pc_plus;
  assign Flush           = flush_q;
  assign RedirectPending = pend_q;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Scoreboard bench for pc_fetch_control: two instances (1 and 3 flush slots) share stimulus.
module tb_pc_fetch_control;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCNew = '0;

  logic [31:0] pc_a, pcp4_a, pc_b, pcp4_b;
  logic        flush_a, pend_a, err_a, flush_b, pend_b, err_b;

  always #5 Clk = ~Clk;

  pc_fetch_control #(.FLUSH_CYCLES(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc), .PCNew(PCNew),
    .PC(pc_a), .PCPlus4(pcp4_a), .Flush(flush_a), .RedirectPending(pend_a),
    .MisalignErr(err_a)
  );

  pc_fetch_control #(.FLUSH_CYCLES(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc), .PCNew(PCNew),
    .PC(pc_b), .PCPlus4(pcp4_b), .Flush(flush_b), .RedirectPending(pend_b),
    .MisalignErr(err_b)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        fl;
    logic        pend;
    logic        err;
  } obs_t;

  obs_t q_a[$];
  obs_t q_b[$];

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, a PC, an optional held target and remaining flush slots.
  int unsigned fc [2] = '{1, 3};
  logic [31:0] m_pc [2];
  logic        m_hv [2];
  logic [31:0] m_ht [2];
  int unsigned m_fl [2];
  logic        m_err[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_hv[k] = 1'b0; m_ht[k] = 32'h0; m_fl[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_apply(input int k, input logic [31:0] t);
    logic [31:0] v;
    v = t;
`ifdef PC_ALIGN_CHECK_EN
    if (v[1:0] != 2'b00) begin
      m_err[k] = 1'b1;
      v = {v[31:2], 2'b00};
    end
`endif
    m_pc[k] = v;
    m_fl[k] = fc[k];
  endtask

  task automatic model_step(input int k, input logic st, input logic src, input logic [31:0] tgt);
    if (m_fl[k] > 0) begin
      if (!st) begin m_pc[k] = m_pc[k] + 32'd4; m_fl[k] = m_fl[k] - 1; end
    end else if (m_hv[k]) begin
      if (!st) begin model_apply(k, m_ht[k]); m_hv[k] = 1'b0; end
    end else if (src) begin
      if (st) begin m_hv[k] = 1'b1; m_ht[k] = tgt; end
      else model_apply(k, tgt);
    end else if (!st) begin
      m_pc[k] = m_pc[k] + 32'd4;
    end
  endtask

  task automatic drive_push(input logic st, input logic src, input logic [31:0] tgt);
    Stall = st; PCSrc = src; PCNew = tgt;
    for (int k = 0; k < 2; k++) model_step(k, st, src, tgt);
    q_a.push_back('{pc: m_pc[0], fl: (m_fl[0] > 0), pend: m_hv[0], err: m_err[0]});
    q_b.push_back('{pc: m_pc[1], fl: (m_fl[1] > 0), pend: m_hv[1], err: m_err[1]});
  endtask

  task automatic step(input logic st, input logic src, input logic [31:0] tgt);
    @(negedge Clk);
    drive_push(st, src, tgt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    Reset = 1'b0; Stall = 1'b0; PCSrc = 1'b0;
    #1;
    model_reset();
    chk("rst_pc_a", pc_a, 32'h0);       chk("rst_pc_b", pc_b, 32'h0);
    chk("rst_flush_a", 32'(flush_a), 0); chk("rst_flush_b", 32'(flush_b), 0);
    chk("rst_pend_a", 32'(pend_a), 0);   chk("rst_pend_b", 32'(pend_b), 0);
    chk("rst_err_a", 32'(err_a), 0);     chk("rst_err_b", 32'(err_b), 0);
    @(posedge Clk);
    #1;
    chk("rst_hold_pc_a", pc_a, 32'h0);  chk("rst_hold_pc_b", pc_b, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    drive_push(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    obs_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("pc_a", pc_a, e.pc);
        chk("pcplus4_a", pcp4_a, e.pc + 32'd4);
        chk("flush_a", 32'(flush_a), 32'(e.fl));
        chk("pend_a", 32'(pend_a), 32'(e.pend));
        chk("err_a", 32'(err_a), 32'(e.err));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("pc_b", pc_b, e.pc);
        chk("pcplus4_b", pcp4_b, e.pc + 32'd4);
        chk("flush_b", 32'(flush_b), 32'(e.fl));
        chk("pend_b", 32'(pend_b), 32'(e.pend));
        chk("err_b", 32'(err_b), 32'(e.err));
      end
    end
  end

  initial begin
    logic        st, src;
    logic [31:0] tgt;
    model_reset();
    do_reset();
    idle(3);
    step(1'b0, 1'b1, 32'h10);  idle(4);
    step(1'b0, 1'b1, 32'h40);  idle(4);
    step(1'b1, 1'b1, 32'h80);  step(1'b1, 1'b1, 32'h99); step(1'b1, 1'b1, 32'h99);
    idle(5);
    step(1'b0, 1'b1, 32'h100); step(1'b0, 1'b0, 32'h0); step(1'b1, 1'b0, 32'h0);
    idle(4);
    step(1'b0, 1'b1, 32'hFFFF_FFF0); idle(8);
    step(1'b0, 1'b1, 32'h42);  idle(4);
    do_reset();
    idle(3);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        st  = ($urandom_range(0, 99) < 30);
        src = ($urandom_range(0, 99) < 35);
        tgt = $urandom;
        if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
        if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
        step(st, src, tgt);
      end
    end
    @(posedge Clk);
    #3;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL drain: entries left a=%0d b=%0d want 0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
